// File: rtl/ram_fifo_pkg.sv
// Shared types and helpers for the RAM-backed FIFO controller.
package ram_fifo_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } ctrl_state_e;

    // Increment that wraps at an arbitrary size, not only at powers of two.
    function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned size);
        return (ptr >= size - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/wrap_ptr.sv
// Modulo-SIZE address counter with increment and synchronous clear.
module wrap_ptr
    import ram_fifo_pkg::*;
#(
    parameter int unsigned SIZE  = 64,
    parameter int unsigned WIDTH = $clog2(SIZE)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (!reset_n || clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= WIDTH'(wrap_inc(32'(ptr), SIZE));
        end
    end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller in front of a read-before-write dual-address RAM.
// Sweeps the RAM to zero after reset or flush before accepting traffic.
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int RAM_SIZE   = 64,
    parameter int ADDR_WIDTH = $clog2(RAM_SIZE)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  in_ready,
    input  logic                  pop,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] ram_w_addr,
    output logic                  ram_w_enable,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    output logic [ADDR_WIDTH-1:0] ram_r_addr,
    input  logic [DATA_WIDTH-1:0] ram_data_out
);

    localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH+1)'(RAM_SIZE);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(RAM_SIZE - 1);

    ctrl_state_e           state;
    logic [ADDR_WIDTH-1:0] clear_addr;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count_next;
    logic                  running;
    logic                  clearing;
    logic                  pop_acc;
    logic                  push_acc;
    logic                  clear_done;

    // Flush outranks traffic, so a flush cycle accepts neither push nor pop.
    assign running    = reset_n && !flush && (state == ST_RUN);
    assign clearing   = reset_n && (state == ST_CLEAR);
    assign pop_acc    = running && pop && !empty;
    assign push_acc   = running && push && (!full || pop_acc);
    assign clear_done = clearing && !flush && (clear_addr == LAST_ADDR);

    assign in_ready     = reset_n && (state == ST_RUN) && (!full || pop);
    assign busy         = (state == ST_CLEAR);
    assign ram_w_enable = clearing || push_acc;
    assign ram_w_addr   = clearing ? clear_addr : wr_ptr;
    assign ram_data_in  = clearing ? '0 : push_data;
    assign ram_r_addr   = rd_ptr;
    assign rd_data      = ram_data_out;

    wrap_ptr #(.SIZE(RAM_SIZE), .WIDTH(ADDR_WIDTH)) u_clear_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (flush),
        .inc     (clearing && !flush),
        .ptr     (clear_addr)
    );

    wrap_ptr #(.SIZE(RAM_SIZE), .WIDTH(ADDR_WIDTH)) u_wr_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (flush),
        .inc     (push_acc),
        .ptr     (wr_ptr)
    );

    wrap_ptr #(.SIZE(RAM_SIZE), .WIDTH(ADDR_WIDTH)) u_rd_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (flush),
        .inc     (pop_acc),
        .ptr     (rd_ptr)
    );

    always_comb begin
        count_next = count;
        case ({push_acc, pop_acc})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            state    <= ST_CLEAR;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            rd_valid <= 1'b0;
        end else begin
            if (clear_done) begin
                state <= ST_RUN;
            end
            count    <= count_next;
            full     <= (count_next == FULL_COUNT);
            empty    <= (count_next == '0);
            rd_valid <= pop_acc;
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed self-checking bench for ram_fifo_ctrl with a behavioural read-before-write RAM.
module tb_ram_fifo_ctrl;

    localparam int DW = 8;
    localparam int RS = 64;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          flush;
    logic          push;
    logic [DW-1:0] push_data;
    logic          in_ready;
    logic          pop;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          busy;
    logic [AW-1:0] ram_w_addr;
    logic          ram_w_enable;
    logic [DW-1:0] ram_data_in;
    logic [AW-1:0] ram_r_addr;
    logic [DW-1:0] ram_data_out;

    logic [DW-1:0] mem [0:RS-1];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_fifo_ctrl #(.DATA_WIDTH(DW), .RAM_SIZE(RS)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush        (flush),
        .push         (push),
        .push_data    (push_data),
        .in_ready     (in_ready),
        .pop          (pop),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .busy         (busy),
        .ram_w_addr   (ram_w_addr),
        .ram_w_enable (ram_w_enable),
        .ram_data_in  (ram_data_in),
        .ram_r_addr   (ram_r_addr),
        .ram_data_out (ram_data_out)
    );

    // Registered read port that samples the old word when reading and writing the same address.
    always @(posedge clk) begin
        if (ram_w_enable) mem[ram_w_addr] <= ram_data_in;
        ram_data_out <= mem[ram_r_addr];
    end

    task automatic applyStimulus(input logic rst_n, input logic fl, input logic ps,
                                 input logic [DW-1:0] pd, input logic pp);
        reset_n   = rst_n;
        flush     = fl;
        push      = ps;
        push_data = pd;
        pop       = pp;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkSweep(input int k);
        checkOutput("clear_sweep",
                    32'({busy, in_ready, rd_valid, ram_w_enable, ram_data_in, ram_w_addr}),
                    32'({1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 6'(k)}));
    endtask

    task automatic checkMemCleared();
        int nonzero = 0;
        for (int a = 0; a < RS; a++) begin
            if (mem[a] !== 8'h00) nonzero++;
        end
        checkOutput("mem_cleared", 32'(nonzero), 32'd0);
    endtask

    initial begin
        logic [DW-1:0] basic [3];
        logic [DW-1:0] prev;
        logic [DW-1:0] exp_word;
        basic[0] = 8'h11;
        basic[1] = 8'h22;
        basic[2] = 8'h33;
        $display("[TB] starting ram_fifo_ctrl bench");

        // Reset held: writes and acceptance suppressed, status at reset values.
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h5A, 1'b1);
        repeat (3) tick();
        checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
        checkOutput("reset_w_enable", 32'(ram_w_enable), 32'd0);
        checkOutput("reset_status", 32'({busy, full, empty, rd_valid, count}),
                    32'({1'b1, 1'b0, 1'b1, 1'b0, 7'd0}));

        // Sweep after release; push and pop are ignored throughout.
        for (int k = 0; k < RS; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 8'hFF, 1'b1);
            checkSweep(k);
            tick();
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("post_clear", 32'({in_ready, busy, empty, count}),
                    32'({1'b1, 1'b0, 1'b1, 7'd0}));
        checkMemCleared();

        // Basic FIFO order.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, basic[i], 1'b0);
            tick();
        end
        checkOutput("basic_count", 32'({empty, count}), 32'({1'b0, 7'd3}));
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
            tick();
            checkOutput("fifo_order", 32'({rd_valid, rd_data}), 32'({1'b1, basic[i]}));
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        checkOutput("basic_drained", 32'({rd_valid, empty, count}), 32'({1'b0, 1'b1, 7'd0}));

        // Fill to capacity, then a rejected push.
        for (int i = 0; i < RS; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 8'(i), 1'b0);
            tick();
        end
        checkOutput("full_status", 32'({full, empty, count}), 32'({1'b1, 1'b0, 7'd64}));
        applyStimulus(1'b1, 1'b0, 1'b1, 8'hAA, 1'b0);
        checkOutput("full_reject", 32'({in_ready, ram_w_enable}), 32'({1'b0, 1'b0}));
        tick();
        checkOutput("full_hold", 32'({full, count}), 32'({1'b1, 7'd64}));

        // Simultaneous push and pop while full share one address.
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h55, 1'b1);
        checkOutput("full_pushpop_addr",
                    32'({in_ready, ram_w_enable, ram_data_in, ram_w_addr, ram_r_addr}),
                    32'({1'b1, 1'b1, 8'h55, 6'd3, 6'd3}));
        tick();
        checkOutput("full_pushpop_read", 32'({rd_valid, rd_data, full, count}),
                    32'({1'b1, 8'h00, 1'b1, 7'd64}));
        checkOutput("full_pushpop_mem", 32'(mem[3]), 32'h55);

        for (int i = 1; i <= RS; i++) begin
            exp_word = (i < RS) ? 8'(i) : 8'h55;
            applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
            tick();
            checkOutput("drain_order", 32'({rd_valid, rd_data}), 32'({1'b1, exp_word}));
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        checkOutput("drain_empty", 32'({rd_valid, empty, count}), 32'({1'b0, 1'b1, 7'd0}));

        // Pop on empty, then push+pop on empty accepts only the push.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        tick();
        checkOutput("empty_pop", 32'({rd_valid, count}), 32'({1'b0, 7'd0}));
        applyStimulus(1'b1, 1'b0, 1'b1, 8'hC0, 1'b1);
        tick();
        checkOutput("empty_pushpop", 32'({rd_valid, count}), 32'({1'b0, 7'd1}));

        // Streaming pairs carry the pointers across the 63 -> 0 boundary.
        prev = 8'hC0;
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 8'(i), 1'b1);
            if (i == 59) begin
                checkOutput("ptr_wrap", 32'({ram_w_addr, ram_r_addr}), 32'({6'd0, 6'd63}));
            end
            tick();
            checkOutput("stream_order", 32'({rd_valid, rd_data, count}), 32'({1'b1, prev, 7'd1}));
            prev = 8'(i);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        tick();
        checkOutput("stream_last", 32'({rd_valid, rd_data, count}), 32'({1'b1, 8'd99, 7'd0}));

        // Flush with ten words stored, competing with push and pop.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
            tick();
        end
        checkOutput("pre_flush_count", 32'(count), 32'd10);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'hEE, 1'b1);
        checkOutput("flush_blocks_push", 32'(ram_w_enable), 32'd0);
        tick();
        checkOutput("flush_status", 32'({busy, empty, rd_valid, count}),
                    32'({1'b1, 1'b1, 1'b0, 7'd0}));
        for (int k = 0; k < RS; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
            checkSweep(k);
            tick();
        end
        checkOutput("post_flush", 32'({in_ready, busy, empty, count}),
                    32'({1'b1, 1'b0, 1'b1, 7'd0}));
        checkMemCleared();

        // Flush during a sweep restarts it at address 0.
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        tick();
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
            checkSweep(k);
            tick();
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        tick();
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
            checkSweep(k);
            tick();
        end

        // Reset during a sweep also restarts it.
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h77, 1'b0);
        checkOutput("midclear_reset", 32'({in_ready, ram_w_enable}), 32'({1'b0, 1'b0}));
        repeat (2) tick();
        for (int k = 0; k < RS; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
            checkSweep(k);
            tick();
        end
        checkOutput("post_reset_clear", 32'({in_ready, busy, empty, count}),
                    32'({1'b1, 1'b0, 1'b1, 7'd0}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_fifo_ctrl.md
# ram_fifo_ctrl

Synchronous FIFO controller that turns the dual-address `ram` block (one write port, one registered read port with read-before-write) into a first-in-first-out queue. It sits directly upstream of `ram` and drives its `w_addr`, `w_enable`, `data_in` and `r_addr` ports. It consumes `ram.data_out` and returns it to the consumer with a valid strobe. After reset or flush it sweeps the whole memory to zero before accepting traffic, so software-visible contents are always defined.

## Interface
- `DATA_WIDTH`, 8, word width; must match the attached `ram`.
- `RAM_SIZE`, 64, depth in words; any value ≥ 2, need not be a power of two.
- `ADDR_WIDTH`, `$clog2(RAM_SIZE)`, address width; derived, not overridden.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `flush` in 1: synchronous request to empty the FIFO and re-clear memory.
- `push` in 1: write request.
- `push_data` in DATA_WIDTH: word to enqueue.
- `in_ready` out 1: controller can accept a push this cycle.
- `pop` in 1: read request.
- `rd_valid` out 1: `rd_data` holds a dequeued word this cycle.
- `rd_data` out DATA_WIDTH: dequeued word, a passthrough of `ram_data_out`.
- `count` out ADDR_WIDTH+1: number of stored words, 0..RAM_SIZE.
- `full` out 1: high when `count == RAM_SIZE`.
- `empty` out 1: high when `count == 0`.
- `busy` out 1: a clear sweep is in progress.
- `ram_w_addr` out ADDR_WIDTH: drives `ram.w_addr`.
- `ram_w_enable` out 1: drives `ram.w_enable`.
- `ram_data_in` out DATA_WIDTH: drives `ram.data_in`.
- `ram_r_addr` out ADDR_WIDTH: drives `ram.r_addr`.
- `ram_data_out` in DATA_WIDTH: from `ram.data_out`.

## Operation
- **States:** `ST_CLEAR` and `ST_RUN`.
- **Reset** (`reset_n` low at an edge):
  - state goes to `ST_CLEAR`; clear address, write pointer, read pointer and `count` go to 0; `rd_valid` goes to 0.
  - While `reset_n` is low, `ram_w_enable` and `in_ready` are forced to 0.
- **ST_CLEAR:**
  - Drives `ram_w_enable`=1, `ram_data_in`=0 and `ram_w_addr`=clear address, one address per cycle.
  - `busy`=1, `in_ready`=0; `push` and `pop` are ignored.
  - After writing address RAM_SIZE-1, moves to `ST_RUN`.
- **ST_RUN:**
  - A push is accepted when `push && (!full || pop_acc)`. On acceptance: `ram_w_enable`=1, `ram_w_addr`=write pointer, `ram_data_in`=`push_data`.
  - A pop is accepted when `pop && !empty` (`pop_acc`). On acceptance: `ram_r_addr`=read pointer.
  - When no pop is accepted, `ram_r_addr` holds the read pointer.
- **Pointers:** advance modulo RAM_SIZE, so RAM_SIZE-1 wraps to 0.
- **count:** next value is `count + push_acc − pop_acc`.
- **Push and pop in the same cycle:**
  - When full, both are accepted. `w_addr == r_addr`, and the RAM's read-before-write returns the old word. `count` is unchanged.
  - When empty, only the push is accepted.
- **flush:** when high at an edge in either state, the controller enters `ST_CLEAR` with all pointers and `count` at 0. Flush during a clear restarts the sweep at address 0. Flush has priority over push and pop in the same cycle.

## Timing
- **Clear duration:** cycle 0 is the first edge with `reset_n` high. Address k is written at edge k, for k = 0..RAM_SIZE-1. `in_ready`=1 and `busy`=0 from the cycle after edge RAM_SIZE-1.
- **Read latency:** a pop accepted at edge N gives `rd_valid`=1 with `rd_data` valid during cycle N+1. `rd_valid` is registered and high for exactly one cycle per accepted pop; back-to-back pops give back-to-back valid cycles.
- **Status outputs:** `count`, `full` and `empty` are registered and reflect the edge just taken.
- **in_ready:** combinational; equals `ST_RUN && (!full || pop)`.
- There is no backpressure on the read side; the consumer must take `rd_data` in the valid cycle.

## Structure
- **Package `ram_fifo_pkg`:**
  - `ctrl_state_e` enum (`ST_CLEAR`, `ST_RUN`).
  - Function `wrap_inc(ptr, size)` for the modulo increment.
- **Sub-module `wrap_ptr`:** a modulo-RAM_SIZE counter with `inc` and synchronous `clr`. It is instantiated three times: clear address, write pointer, read pointer.
- `ram` itself is not instantiated here. A thin top `ram_fifo` instantiates `ram_fifo_ctrl` and `ram`.

## Test plan
All scenarios use DATA_WIDTH=8 and RAM_SIZE=64.
- **Reset and clear:** reset then release → `ram_w_addr` steps 0..63 with data 0 over 64 cycles; `busy`=1 throughout; then `in_ready`=1, `empty`=1, `count`=0.
- **Basic FIFO order:** push 0x11, 0x22, 0x33, then pop ×3 → `rd_data` 0x11, 0x22, 0x33 each one cycle after its pop; `empty`=1 at the end.
- **Full:** push 64 words 0x00..0x3F, then push 0xAA → `full`=1, `in_ready`=0, 0xAA is not written, `count`=64; next pop returns 0x00.
- **Full with simultaneous push and pop:** push 0x55 and pop in the same cycle → both accepted; `count` stays 64; read returns the oldest word; 0x55 lands at that same address.
- **Empty pop and wrap:** pop while empty → `rd_valid` stays 0 and `count` stays 0. Then 100 push/pop pairs with incrementing data → pointers wrap 63→0 and data order is preserved.
- **Flush and reset mid-operation:** flush with `count`=10 → re-clear of 64 cycles, `count`=0. `reset_n` low mid-clear → sweep restarts at address 0.
